// File: rtl/prog_mem.sv
// prog_mem: loadable instruction memory with registered fetch.
// Fetches at or beyond the loaded length return HALT_WORD.
module prog_mem #(
    parameter int LINE_WIDTH = 32,
    parameter int IP_WIDTH = 8,
    parameter int DEPTH = 256,
    parameter logic [LINE_WIDTH-1:0] HALT_WORD = 32'hFFFFFFFF
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic [LINE_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  load_ready,
    input  logic                  fetch_en,
    input  logic [IP_WIDTH-1:0]   ip,
    output logic [LINE_WIDTH-1:0] line,
    output logic                  line_valid,
    output logic                  fetch_oob,
    output logic [IP_WIDTH:0]     prog_len,
    output logic                  run
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [IP_WIDTH:0] DEPTH_W = (IP_WIDTH+1)'(DEPTH);
    localparam logic [IP_WIDTH:0] LAST_W = (IP_WIDTH+1)'(DEPTH - 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN = 2'd2;

    logic [LINE_WIDTH-1:0] mem [DEPTH];
    logic [1:0]            state_q, state_d;
    logic [IP_WIDTH:0]     len_q, len_d;
    logic [LINE_WIDTH-1:0] line_q, line_d;
    logic                  line_valid_q, line_valid_d;
    logic                  oob_q, oob_d;
    logic                  wr_en, fetch, in_range;

    // The write pointer always equals the loaded length, so one counter serves both.
    always_comb begin
        load_ready = state_q == LOAD && len_q < DEPTH_W;
        wr_en = load_ready && load_valid && !load_start;
        fetch = state_q == RUN && fetch_en && !load_start;
        in_range = {1'b0, ip} < len_q;
        state_d = state_q;
        len_d = len_q;
        if (load_start) begin
            state_d = LOAD;
            len_d = '0;
        end else if (wr_en) begin
            len_d = len_q + 1'b1;
            state_d = (load_last || len_q == LAST_W) ? RUN : LOAD;
        end
        line_valid_d = fetch;
        line_d = fetch ? (in_range ? mem[ip[AW-1:0]] : HALT_WORD) : line_q;
        oob_d = fetch ? !in_range : oob_q;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            len_q <= '0;
            line_q <= HALT_WORD;
            line_valid_q <= 1'b0;
            oob_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q <= len_d;
            line_q <= line_d;
            line_valid_q <= line_valid_d;
            oob_q <= oob_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[len_q[AW-1:0]] <= load_data;
    end

    assign line = line_q;
    assign line_valid = line_valid_q;
    assign fetch_oob = oob_q;
    assign prog_len = len_q;
    assign run = state_q == RUN;
endmodule

// File: tb/tb_prog_mem.sv
// tb_prog_mem: directed vector table, hand sequences for DEPTH=4 fill and
// mid-load reset, then randomized traffic against a behavioural model.
module tb_prog_mem;
    localparam logic [31:0] H = 32'hFFFFFFFF;

    logic        clk = 0, n_rst = 0;
    logic        load_start = 0, load_valid = 0, load_last = 0, fetch_en = 0;
    logic [31:0] load_data = 0;
    logic [7:0]  ip = 0;
    logic        load_ready, line_valid, fetch_oob, run;
    logic [31:0] line;
    logic [8:0]  prog_len;
    logic        load_ready4, line_valid4, fetch_oob4, run4;
    logic [31:0] line4;
    logic [8:0]  prog_len4;

    int checks = 0, errors = 0;

    prog_mem dut (
        .clk(clk), .n_rst(n_rst), .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
        .fetch_en(fetch_en), .ip(ip), .line(line), .line_valid(line_valid),
        .fetch_oob(fetch_oob), .prog_len(prog_len), .run(run)
    );

    prog_mem #(.DEPTH(4)) dut4 (
        .clk(clk), .n_rst(n_rst), .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_ready(load_ready4),
        .fetch_en(fetch_en), .ip(ip), .line(line4), .line_valid(line_valid4),
        .fetch_oob(fetch_oob4), .prog_len(prog_len4), .run(run4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ls, lv;
        logic [31:0] d;
        logic        last, fe;
        logic [7:0]  ip;
        logic [31:0] e_line;
        logic        e_lv, e_oob;
        logic [8:0]  e_len;
        logic        e_run, e_rdy;
    } vec_t;

    vec_t vecs[$];

    logic [31:0] prog [8] = '{32'h03000000, 32'h03010000, 32'h03020600, 32'h03030500,
                              32'h50080102, 32'h00000003, 32'h02010101, 32'h40040000};

    // Behavioural model: a plain array plus a length and two mode flags.
    logic [31:0] m_mem [256];
    int          m_len;
    bit          m_load, m_run, m_lv, m_oob;
    logic [31:0] m_line;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic row(input logic ls, lv, input logic [31:0] d, input logic last, fe,
                       input logic [7:0] a, input logic [31:0] el, input logic elv, eoob,
                       input logic [8:0] elen, input logic erun, erdy);
        vec_t v;
        v = '{ls, lv, d, last, fe, a, el, elv, eoob, elen, erun, erdy};
        vecs.push_back(v);
    endtask

    task automatic apply(input logic ls, lv, input logic [31:0] d, input logic last, fe,
                         input logic [7:0] a);
        load_start = ls; load_valid = lv; load_data = d; load_last = last;
        fetch_en = fe; ip = a;
        @(posedge clk);
        #1;
    endtask

    task automatic model_step(input logic ls, lv, input logic [31:0] d, input logic last, fe,
                              input logic [7:0] a);
        m_lv = 0;
        if (m_run) begin
            if (ls) begin
                m_run = 0; m_load = 1; m_len = 0;
            end else if (fe) begin
                m_lv = 1;
                m_oob = int'(a) >= m_len;
                m_line = m_oob ? H : m_mem[a];
            end
        end else if (m_load) begin
            if (ls) m_len = 0;
            else if (lv && m_len < 256) begin
                m_mem[m_len] = d;
                m_len++;
                if (last || m_len == 256) begin
                    m_load = 0; m_run = 1;
                end
            end
        end else if (ls) begin
            m_load = 1; m_len = 0;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_line", line, H);
        chk("rst_lv", line_valid, 0);
        chk("rst_oob", fetch_oob, 0);
        chk("rst_rdy", load_ready, 0);
        chk("rst_len", prog_len, 0);
        chk("rst_run", run, 0);
        @(negedge clk);
        n_rst = 1;

        row(0,0,0,0,1,0, H,0,0,0,0,0);
        row(1,0,0,0,0,0, H,0,0,0,0,1);
        for (int i = 0; i < 8; i++)
            row(0,1,prog[i],i==7,0,0, H,0,0,9'(i+1),i==7,i!=7);
        row(0,0,0,0,1,4,   32'h50080102,1,0,8,1,0);
        row(0,0,0,0,1,8,   H,1,1,8,1,0);
        row(0,0,0,0,1,255, H,1,1,8,1,0);
        row(0,0,0,0,1,7,   32'h40040000,1,0,8,1,0);
        row(0,0,0,0,0,0,   32'h40040000,0,0,8,1,0);
        row(1,0,0,0,1,0,   32'h40040000,0,0,0,0,1);
        for (int i = 0; i < 3; i++)
            row(0,1,32'hA0000000+i,0,0,0, 32'h40040000,0,0,9'(i+1),0,1);
        row(1,1,32'h99999999,0,0,0, 32'h40040000,0,0,0,0,1);
        row(0,1,32'h11111111,0,0,0, 32'h40040000,0,0,1,0,1);
        row(0,1,32'h22222222,1,0,0, 32'h40040000,0,0,2,1,0);
        row(0,0,0,0,1,0, 32'h11111111,1,0,2,1,0);
        row(0,0,0,0,1,1, 32'h22222222,1,0,2,1,0);
        row(0,0,0,0,1,2, H,1,1,2,1,0);
        row(0,1,32'hDEADBEEF,1,0,0, H,0,1,2,1,0);

        foreach (vecs[i]) begin
            apply(vecs[i].ls, vecs[i].lv, vecs[i].d, vecs[i].last, vecs[i].fe, vecs[i].ip);
            chk($sformatf("v%0d_line", i), line, vecs[i].e_line);
            chk($sformatf("v%0d_lv", i), line_valid, vecs[i].e_lv);
            chk($sformatf("v%0d_oob", i), fetch_oob, vecs[i].e_oob);
            chk($sformatf("v%0d_len", i), prog_len, vecs[i].e_len);
            chk($sformatf("v%0d_run", i), run, vecs[i].e_run);
            chk($sformatf("v%0d_rdy", i), load_ready, vecs[i].e_rdy);
        end

        // DEPTH=4 fill: two words beyond capacity are refused and RUN is automatic.
        apply(1,0,0,0,0,0);
        chk("d4_start_len", prog_len4, 0);
        chk("d4_start_rdy", load_ready4, 1);
        for (int k = 1; k <= 6; k++) begin
            apply(0,1,32'hC0000000+k,0,0,0);
            chk($sformatf("d4_len%0d", k), prog_len4, (k < 4) ? k : 4);
            chk($sformatf("d4_rdy%0d", k), load_ready4, k < 4);
            chk($sformatf("d4_run%0d", k), run4, k >= 4);
        end
        chk("d256_len6", prog_len, 6);
        apply(0,0,0,0,1,3);
        chk("d4_ip3_line", line4, 32'hC0000004);
        chk("d4_ip3_oob", fetch_oob4, 0);
        apply(0,0,0,0,1,4);
        chk("d4_ip4_line", line4, H);
        chk("d4_ip4_oob", fetch_oob4, 1);

        // Asynchronous reset in the middle of a load.
        apply(1,0,0,0,0,0);
        for (int k = 0; k < 5; k++) apply(0,1,$urandom,0,0,0);
        chk("mid_len5", prog_len, 5);
        #2 n_rst = 0;
        #1;
        chk("arst_len", prog_len, 0);
        chk("arst_rdy", load_ready, 0);
        chk("arst_run", run, 0);
        chk("arst_line", line, H);
        @(negedge clk);
        n_rst = 1;
        apply(0,0,0,0,1,0);
        chk("arst_fetch_lv", line_valid, 0);
        chk("arst_fetch_run", run, 0);

        // Randomized traffic against the model, starting from a fresh reset.
        n_rst = 0;
        @(negedge clk);
        n_rst = 1;
        m_len = 0; m_load = 0; m_run = 0; m_lv = 0; m_oob = 0; m_line = H;
        for (int c = 0; c < 600; c++) begin
            logic        r_ls, r_lv, r_last, r_fe;
            logic [31:0] r_d;
            logic [7:0]  r_ip;
            r_ls = $urandom_range(0, 31) == 0;
            r_lv = 1'($urandom_range(0, 1));
            r_d = $urandom;
            r_last = $urandom_range(0, 7) == 0;
            r_fe = 1'($urandom_range(0, 1));
            r_ip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
            model_step(r_ls, r_lv, r_d, r_last, r_fe, r_ip);
            apply(r_ls, r_lv, r_d, r_last, r_fe, r_ip);
            chk($sformatf("r%0d_line", c), line, m_line);
            chk($sformatf("r%0d_lv", c), line_valid, m_lv);
            chk($sformatf("r%0d_oob", c), fetch_oob, m_oob);
            chk($sformatf("r%0d_len", c), prog_len, 9'(m_len));
            chk($sformatf("r%0d_run", c), run, m_run);
            chk($sformatf("r%0d_rdy", c), load_ready, m_load && m_len < 256);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
